memory_stream_reader: RTL

Sequential read-out engine for the data memory port of `memory_datapath`. Given a base address and word count, it issues one read per cycle to a synchronous-read memory port. Returned words are buffered in a 4-entry FIFO and presented on a valid/ready output stream, so a slow consumer (debug dump, UART bridge, checker) can drain memory without stalling the read pipeline incorrectly. It is the reading counterpart of the datapath's write path and sits beside it on the same memory port.

---
 rtl/memory_stream_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/memory_stream_reader.sv
// Streams a block of words out of a synchronous-read memory port into a
// 4-entry FIFO that feeds a valid/ready consumer.
module memory_stream_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_lastAddr;
  logic [15:0]       r_remain;
  logic [15:0]       r_count;
  logic [15:0]       r_accepted;
  logic              r_inflight;

  logic [DATA_W-1:0] r_fifo [4];
  logic [1:0]        r_wrPtr;
  logic [1:0]        r_rdPtr;
  logic [2:0]        r_occ;

  logic [3:0]        w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_lastPop;
  logic              w_accept;

  // Credits count both buffered words and the read still in the memory
  // pipeline, so an issued read always has a FIFO slot waiting for it.
  assign w_credit  = {1'b0, r_occ} + {3'b000, r_inflight};
  assign w_issue   = (r_state == READ) && (r_remain != 16'd0) && (w_credit < 4'd4);
  assign w_push    = r_inflight;
  assign w_pop     = (r_occ != 3'd0) && out_ready;
  assign w_lastPop = w_pop && (r_accepted == (r_count - 16'd1));
  assign w_accept  = (r_state == IDLE) && start;

  assign mem_rd_en = w_issue;
  assign mem_addr  = w_issue ? r_addr : r_lastAddr;
  assign out_valid = (r_occ != 3'd0);
  assign out_data  = (r_occ != 3'd0) ? r_fifo[r_rdPtr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = (count == 16'd0) ? DONE : READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if (w_issue && (r_remain == 16'd1)) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (w_lastPop) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Clearing r_inflight on reset is what drops a read that returns afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr     <= '0;
      r_lastAddr <= '0;
      r_remain   <= 16'd0;
      r_count    <= 16'd0;
      r_accepted <= 16'd0;
      r_inflight <= 1'b0;
      r_wrPtr    <= 2'd0;
      r_rdPtr    <= 2'd0;
      r_occ      <= 3'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_accept) begin
        r_addr     <= base_addr;
        r_remain   <= count;
        r_count    <= count;
        r_accepted <= 16'd0;
      end
      if (w_issue) begin
        r_addr     <= r_addr + ADDR_W'(1);
        r_lastAddr <= r_addr;
        r_remain   <= r_remain - 16'd1;
      end
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 2'd1;
      end
      if (w_pop) begin
        r_rdPtr    <= r_rdPtr + 2'd1;
        r_accepted <= r_accepted + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_push) begin
      r_fifo[r_wrPtr] <= mem_rd_data;
    end
  end

endmodule
